pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Works beside the EXE-stage operand forwarding logic.
//  Forwarding covers ALU results from MEM/WB; this block covers what forwarding cannot:
//  load-use bubbles, multi-cycle divider occupancy of EXE, D-cache miss freezes and exception flushes.
//  Drives per-stage write-enables (hold) and flushes (bubble insert) for PC, IF_ID, ID_EXE, EXE_MEM, MEM_WB.
// PARAMETERS
//  DIV_CYCLES  36  cycles a divide occupies EXE, start cycle included; legal range 2..63
// PORTS
//  clk             in   1  single clock; all state updates on posedge clk
//  resetn          in   1  synchronous, active-low reset
//  ID_rs           in   5  rs index of instruction in ID
//  ID_rt           in   5  rt index of instruction in ID
//  EXE_IsLoad      in   1  EXE holds a load
//  EXE_Dst         in   5  EXE destination register
//  EXE_DivStart    in   1  EXE holds div/divu; stays high while that instruction is held in EXE
//  MEM_DReq        in   1  MEM stage has an outstanding D-cache access
//  MEM_DReady      in   1  D-cache data/ack valid this cycle
//  WB_Exception    in   1  exception committed at WB
//  PC_Wr,IF_ID_Wr,ID_EXE_Wr,EXE_MEM_Wr,MEM_WB_Wr  out 1 each  stage register enables (0 = hold)
//  IF_ID_Flush,ID_EXE_Flush,EXE_MEM_Flush,MEM_WB_Flush  out 1 each  load a bubble into that register
//  DIV_ResultValid out  1  divider result may be taken by EXE this cycle
//  HZ_State        out  2  current FSM state (debug/perf counters)
// BEHAVIOUR
//  Reset: clk and resetn as above; resetn is synchronous and active-low.
//   - Reset values: state=HZ_RUN, div_cnt=0, ret_q=HZ_RUN.
//   - While resetn=0: all *_Wr=0, all *_Flush=1, DIV_ResultValid=0.
//  Outputs are combinational from state/counters and inputs. Defaults: every *_Wr=1, every *_Flush=0.
//  FSM states: HZ_RUN, HZ_DIV, HZ_MEM. Conditions are evaluated in priority order; the first match wins.
//  P1 WB_Exception (any state):
//   - All four flushes=1, PC_Wr=1 (handler fetch).
//   - next state=HZ_RUN; div_cnt<=0; ret_q<=HZ_RUN.
//   - Aborts any pending miss; the cache drops the request.
//  P2 miss: MEM_DReq & !MEM_DReady (in HZ_RUN or HZ_DIV), or state==HZ_MEM & !MEM_DReady:
//   - PC..EXE_MEM _Wr=0, MEM_WB_Flush=1.
//   - On entry, ret_q<=current state, then go to HZ_MEM. div_cnt is frozen.
//  P3 HZ_MEM & MEM_DReady:
//   - Release: this cycle behaves exactly as state ret_q would, evaluated at P4..P6.
//   - next state=ret_q.
//  P4 HZ_RUN & EXE_DivStart:
//   - PC_Wr=IF_ID_Wr=ID_EXE_Wr=0, EXE_MEM_Flush=1.
//   - div_cnt<=DIV_CYCLES-1; next state=HZ_DIV.
//  P5 HZ_DIV:
//   - EXE_DivStart is ignored.
//   - div_cnt>1: same hold/bubble as P4; div_cnt decrements.
//   - div_cnt==1: DIV_ResultValid=1, no stall, pipeline advances; next state=HZ_RUN, div_cnt<=0.
//   - Net effect: a divide occupies EXE for exactly DIV_CYCLES cycles and is never retriggered.
//  P6 HZ_RUN load-use: EXE_IsLoad & EXE_Dst!=0 & (EXE_Dst==ID_rs | EXE_Dst==ID_rt):
//   - PC_Wr=IF_ID_Wr=0, ID_EXE_Flush=1.
//   - Exactly one bubble; no state change.
//  Boundaries:
//   - Miss and DivStart in the same cycle: the miss wins; DivStart is re-sampled on return to HZ_RUN.
//   - Miss during HZ_DIV: return to HZ_DIV with the counter unchanged.
//   - Miss asserted with DReady=1 in the same cycle: no stall.
//   - EXE_Dst==0 never causes a load-use stall.
//   - resetn low mid-divide or mid-miss: immediate return to reset values on the next edge.
// STRUCTURE
//  Shared package CPU_Defines.svh:
//   - typedef enum logic[1:0] {HZ_RUN=0,HZ_DIV=1,HZ_MEM=2} HzState_t;
//   - typedef struct packed {logic Wr; logic Flush;} StageCtrl_t;
//   - constant DIV_CYCLES_DEFAULT=36.
//  One sub-module, hazard_div_counter: 6-bit load/decrement/freeze/clear counter; outputs cnt_is_one.
//  Priority logic and the FSM live in the top module.
// TESTING
//  1 Load-use: lw r5 in EXE, ID rs=5 -> one cycle PC_Wr=IF_ID_Wr=0, ID_EXE_Flush=1; next cycle all defaults.
//  2 Load-use guard: lw r0 in EXE, ID rs=0; then lw r5 in EXE, ID rs=6/rt=7 -> no stall in either case.
//  3 Divide, DIV_CYCLES=4, DivStart held high: stall at cycles 0-2, DIV_ResultValid=1 at cycle 3, HZ_RUN at cycle 4, no retrigger.
//  4 Miss in HZ_DIV at div_cnt=2, DReady after 5 cycles -> HZ_MEM for 5 cycles, MEM_WB_Flush=1; return to HZ_DIV with cnt=2; total EXE occupancy 9 cycles.
//  5 Simultaneous DivStart + miss -> HZ_MEM first; on DReady the div starts (counter loaded 3); ReqReady same cycle -> no stall.
//  6 WB_Exception during HZ_MEM and during HZ_DIV -> all flushes=1, PC_Wr=1, next state HZ_RUN, cnt=0.
//    Then resetn=0 for 1 cycle mid-divide -> reset values on the next edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared hazard-control types and constants.
//   HzState_t          : sequencer state encoding (also exported on HZ_State)
//   StageCtrl_t        : per-stage register control pair (write-enable, bubble)
//   DIV_CYCLES_DEFAULT : default EXE occupancy of a divide, start cycle included
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned CNT_W              = 6;
  localparam int unsigned DIV_CYCLES_DEFAULT = 36;

  typedef enum logic [1:0] {
    HZ_RUN = 2'd0,
    HZ_DIV = 2'd1,
    HZ_MEM = 2'd2
  } HzState_t;

  typedef struct packed {
    logic Wr;
    logic Flush;
  } StageCtrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_div_counter.sv
// Divider occupancy counter: load / decrement / freeze / clear.
//   clk, resetn : clock, synchronous active-low reset
//   clr         : force count to zero (highest priority)
//   load        : load load_val
//   dec         : decrement by one
//   cnt         : current count
//   cnt_is_one  : count equals one (last divide cycle)
module hazard_div_counter
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_is_one
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count; holding none of the controls freezes the value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt        = cnt_q;
  assign cnt_is_one = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Covers hazards that
// forwarding cannot: load-use bubbles, divider occupancy of EXE, D-cache
// miss freezes and exception flushes.
//   clk, resetn          : clock, synchronous active-low reset
//   ID_rs, ID_rt         : source registers of the instruction in ID
//   EXE_IsLoad, EXE_Dst  : load flag / destination of the instruction in EXE
//   EXE_DivStart         : EXE holds a divide (held high while it stays in EXE)
//   MEM_DReq, MEM_DReady : outstanding D-cache access / data valid
//   WB_Exception         : exception committed at WB
//   *_Wr                 : stage register enables (0 = hold)
//   *_Flush              : load a bubble into that stage register
//   DIV_ResultValid      : divider result may be taken this cycle
//   HZ_State             : current sequencer state
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       EXE_IsLoad,
  input  logic [4:0] EXE_Dst,
  input  logic       EXE_DivStart,
  input  logic       MEM_DReq,
  input  logic       MEM_DReady,
  input  logic       WB_Exception,
  output logic       PC_Wr,
  output logic       IF_ID_Wr,
  output logic       ID_EXE_Wr,
  output logic       EXE_MEM_Wr,
  output logic       MEM_WB_Wr,
  output logic       IF_ID_Flush,
  output logic       ID_EXE_Flush,
  output logic       EXE_MEM_Flush,
  output logic       MEM_WB_Flush,
  output logic       DIV_ResultValid,
  output logic [1:0] HZ_State
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  HzState_t state_q, state_d;
  HzState_t ret_q, ret_d;
  HzState_t eff_state;

  StageCtrl_t if_id_c, id_exe_c, exe_mem_c, mem_wb_c;
  logic       pc_wr_c;
  logic       div_valid_c;

  logic             cnt_clr, cnt_load, cnt_dec;
  logic [CNT_W-1:0] div_cnt;
  logic             div_cnt_is_one;
  logic             miss;
  logic             load_use;

  hazard_div_counter u_div_counter (
    .clk        (clk),
    .resetn     (resetn),
    .clr        (cnt_clr),
    .load       (cnt_load),
    .load_val   (DIV_LOAD),
    .dec        (cnt_dec),
    .cnt        (div_cnt),
    .cnt_is_one (div_cnt_is_one)
  );

  // A pending miss freezes everything; in HZ_MEM only DReady releases it.
  assign miss = (state_q == HZ_MEM) ? !MEM_DReady : (MEM_DReq && !MEM_DReady);

  assign load_use = EXE_IsLoad && (EXE_Dst != 5'd0) &&
                    ((EXE_Dst == ID_rs) || (EXE_Dst == ID_rt));

  // Priority-ordered hazard resolution and next-state logic.
  always_comb begin
    pc_wr_c     = 1'b1;
    if_id_c     = '{Wr: 1'b1, Flush: 1'b0};
    id_exe_c    = '{Wr: 1'b1, Flush: 1'b0};
    exe_mem_c   = '{Wr: 1'b1, Flush: 1'b0};
    mem_wb_c    = '{Wr: 1'b1, Flush: 1'b0};
    div_valid_c = 1'b0;
    state_d     = state_q;
    ret_d       = ret_q;
    cnt_clr     = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    // On release from HZ_MEM this cycle acts as the saved state would.
    eff_state   = (state_q == HZ_MEM) ? ret_q : state_q;

    if (!resetn) begin
      pc_wr_c   = 1'b0;
      if_id_c   = '{Wr: 1'b0, Flush: 1'b1};
      id_exe_c  = '{Wr: 1'b0, Flush: 1'b1};
      exe_mem_c = '{Wr: 1'b0, Flush: 1'b1};
      mem_wb_c  = '{Wr: 1'b0, Flush: 1'b1};
    end else if (WB_Exception) begin
      if_id_c.Flush   = 1'b1;
      id_exe_c.Flush  = 1'b1;
      exe_mem_c.Flush = 1'b1;
      mem_wb_c.Flush  = 1'b1;
      state_d         = HZ_RUN;
      ret_d           = HZ_RUN;
      cnt_clr         = 1'b1;
    end else if (miss) begin
      pc_wr_c        = 1'b0;
      if_id_c.Wr     = 1'b0;
      id_exe_c.Wr    = 1'b0;
      exe_mem_c.Wr   = 1'b0;
      mem_wb_c.Flush = 1'b1;
      if (state_q != HZ_MEM) begin
        ret_d = state_q;
      end
      state_d = HZ_MEM;
    end else begin
      state_d = eff_state;
      if (eff_state == HZ_DIV) begin
        // EXE_DivStart is ignored here so a held divide never retriggers.
        if (div_cnt > CNT_W'(1)) begin
          pc_wr_c         = 1'b0;
          if_id_c.Wr      = 1'b0;
          id_exe_c.Wr     = 1'b0;
          exe_mem_c.Flush = 1'b1;
          cnt_dec         = 1'b1;
        end else begin
          div_valid_c = div_cnt_is_one;
          state_d     = HZ_RUN;
          cnt_clr     = 1'b1;
        end
      end else if (EXE_DivStart) begin
        pc_wr_c         = 1'b0;
        if_id_c.Wr      = 1'b0;
        id_exe_c.Wr     = 1'b0;
        exe_mem_c.Flush = 1'b1;
        cnt_load        = 1'b1;
        state_d         = HZ_DIV;
      end else if (load_use) begin
        pc_wr_c        = 1'b0;
        if_id_c.Wr     = 1'b0;
        id_exe_c.Flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= HZ_RUN;
      ret_q   <= HZ_RUN;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  assign PC_Wr           = pc_wr_c;
  assign IF_ID_Wr        = if_id_c.Wr;
  assign ID_EXE_Wr       = id_exe_c.Wr;
  assign EXE_MEM_Wr      = exe_mem_c.Wr;
  assign MEM_WB_Wr       = mem_wb_c.Wr;
  assign IF_ID_Flush     = if_id_c.Flush;
  assign ID_EXE_Flush    = id_exe_c.Flush;
  assign EXE_MEM_Flush   = exe_mem_c.Flush;
  assign MEM_WB_Flush    = mem_wb_c.Flush;
  assign DIV_ResultValid = div_valid_c;
  assign HZ_State        = state_q;

endmodule
